host_frame_codec: RTL and testbench
===================================

// Module: host_frame_codec
// PURPOSE
//  Byte-serial host link <-> 34-bit FIFO word codec, host side of the TX/RX register bridge.
//  Host->device: packs 5-byte host frames into {addr[1:0],data[31:0]} words pushed to the down FIFO.
//  Device->host: pops words from the up FIFO, serialises them as 5-byte frames to the host byte port.
//  Frame: byte0 header {HDR_MAGIC[3:0],2'b00,addr[1:0]}, bytes1..4 data, LSB first.
// PARAMETERS
//  HDR_MAGIC       4'hA   required upper nibble of every header byte
//  TIMEOUT_CYCLES  1000   max idle cycles between bytes of one rx frame (>=2)
// PORTS
//  clk                      in   1   system clock, all logic on rising edge
//  rst                      in   1   synchronous reset, active high
//  rx_byte                  in   8   host byte in
//  rx_valid                 in   1   rx_byte valid, one byte per high cycle, no back-pressure
//  tx_byte                  out  8   host byte out
//  tx_valid                 out  1   tx_byte valid
//  tx_ready                 in   1   host accepts tx_byte when tx_valid&&tx_ready
//  down_fifo_write_data     out  34  {addr,data} word to down FIFO
//  down_fifo_write_inc      out  1   push strobe, one cycle per word
//  down_fifo_write_full     in   1   down FIFO full
//  up_fifo_read_data        in   34  head word of up FIFO (first-word-fall-through)
//  up_fifo_read_inc         out  1   pop strobe, one cycle per word
//  up_fifo_read_empty       in   1   up FIFO empty
//  frame_err                out  1   1-cycle pulse: bad header or inter-byte timeout
//  rx_drop                  out  1   1-cycle pulse: rx byte discarded while waiting on full FIFO
// BEHAVIOUR
//  Reset: all outputs 0; both FSMs to idle; partial frames, byte counters, timeout counter cleared.
//  Reset mid-frame: rx frame discarded, tx frame abandoned (word already popped is lost), no strobes.
//  RX FSM R_IDLE -> R_DATA -> R_PUSH -> R_IDLE:
//   R_IDLE: rx_valid && byte[7:4]==HDR_MAGIC && byte[3:2]==0 -> latch addr, cnt=0, R_DATA.
//           rx_valid with any other byte -> frame_err pulse next cycle, stay R_IDLE.
//   R_DATA: each rx_valid stores byte into data[8*cnt+:8], cnt++; 4th byte -> R_PUSH.
//           timeout counter cleared on each accepted byte; reaches TIMEOUT_CYCLES-1 with
//           no byte -> frame_err pulse, data discarded, R_IDLE.
//   R_PUSH: !full -> down_fifo_write_inc=1 for exactly one cycle, data stable that cycle, R_IDLE.
//           full -> hold state and data; any rx_valid here -> byte dropped, rx_drop pulse.
//   Latency: last data byte at edge N, write_inc high in cycle N+1 if full low.
//   Header arriving in same cycle as R_PUSH->R_IDLE is dropped (rx_drop).
//  TX FSM T_IDLE -> T_SEND -> T_IDLE:
//   T_IDLE: !empty sampled at edge N -> latch read_data, up_fifo_read_inc=1 in cycle N+1
//           only (single pulse), T_SEND with idx=0.
//   T_SEND: tx_valid=1, tx_byte = idx0 header {HDR_MAGIC,2'b00,addr}, idx1..4 data bytes LSB first.
//           tx_byte/tx_valid held stable until tx_valid&&tx_ready; then idx++;
//           handshake on idx4 -> T_IDLE, tx_valid low next cycle.
//   Min 1 idle cycle between frames; back-to-back words need no other gap.
//  RX and TX paths independent; simultaneous activity allowed.
//  frame_err/rx_drop registered, never held >1 cycle per event.
// TESTING
//  1 rx A1,78,56,34,12 -> one write_inc, data=34'h1_12345678, cycle after byte 5.
//  2 rx 51 -> frame_err pulse, no write; then A0,01,00,00,00 -> write data=34'h0_00000001.
//  3 TIMEOUT_CYCLES=16: rx A2,11,22 then idle 16 cycles -> frame_err, no write; next frame accepted.
//  4 full=1 at byte 5, extra rx byte -> rx_drop, no inc; full=0 -> single inc, data=34'h1_12345678.
//  5 up word 34'h3_00000001, empty=0, tx_ready toggling -> one read_inc pulse, bytes A3,01,00,00,00
//    in order, each held stable while ready=0.
//  6 rst=1 during tx byte 2 -> tx_valid=0 next cycle, no further read_inc until new !empty.

Source files
------------

// File: rtl/host_frame_codec.sv
// Host byte link <-> 34-bit FIFO word codec: packs 5-byte host frames into {addr,data} words
// for the down FIFO, and serialises up-FIFO words back into 5-byte frames.
module host_frame_codec #(
  parameter logic [3:0] HDR_MAGIC      = 4'hA,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [33:0] down_fifo_write_data,
  output logic        down_fifo_write_inc,
  input  logic        down_fifo_write_full,
  input  logic [33:0] up_fifo_read_data,
  output logic        up_fifo_read_inc,
  input  logic        up_fifo_read_empty,
  output logic        frame_err,
  output logic        rx_drop
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PUSH} rx_state_t;
  typedef enum logic       {T_IDLE, T_SEND} tx_state_t;

  rx_state_t       rx_state_q, rx_state_d;
  logic [1:0]      addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_drop_q, rx_drop_d;

  tx_state_t       tx_state_q, tx_state_d;
  logic [33:0]     word_q, word_d;
  logic [2:0]      idx_q, idx_d;
  logic            read_inc_q, read_inc_d;

  logic            hdr_ok;
  assign hdr_ok = (rx_byte[7:4] == HDR_MAGIC) && (rx_byte[3:2] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= R_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      frame_err_q <= 1'b0;
      rx_drop_q   <= 1'b0;
      tx_state_q  <= T_IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      read_inc_q  <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      frame_err_q <= frame_err_d;
      rx_drop_q   <= rx_drop_d;
      tx_state_q  <= tx_state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      read_inc_q  <= read_inc_d;
    end
  end

  always_comb begin
    rx_state_d          = rx_state_q;
    addr_d              = addr_q;
    data_d              = data_q;
    cnt_d               = cnt_q;
    timer_d             = timer_q;
    frame_err_d         = 1'b0;
    rx_drop_d           = 1'b0;
    down_fifo_write_inc = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        timer_d = '0;
        if (rx_valid) begin
          if (hdr_ok) begin
            addr_d     = rx_byte[1:0];
            data_d     = '0;
            cnt_d      = '0;
            rx_state_d = R_DATA;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      R_DATA: begin
        if (rx_valid) begin
          data_d[{cnt_q, 3'b000} +: 8] = rx_byte;
          cnt_d   = cnt_q + 2'd1;
          timer_d = '0;
          if (cnt_q == 2'd3) rx_state_d = R_PUSH;
        end else if (timer_q == TIMER_LAST) begin
          frame_err_d = 1'b1;
          timer_d     = '0;
          rx_state_d  = R_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      R_PUSH: begin
        // No back-pressure on the host link, so anything arriving while the word waits is lost.
        if (rx_valid) rx_drop_d = 1'b1;
        if (!down_fifo_write_full) begin
          down_fifo_write_inc = 1'b1;
          rx_state_d          = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    read_inc_d = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!up_fifo_read_empty) begin
          word_d     = up_fifo_read_data;
          idx_d      = '0;
          read_inc_d = 1'b1;
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        if (tx_ready) begin
          if (idx_q == 3'd4) tx_state_d = T_IDLE;
          else               idx_d      = idx_q + 3'd1;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    tx_byte = 8'h00;
    if (tx_state_q == T_SEND) begin
      case (idx_q)
        3'd0:    tx_byte = {HDR_MAGIC, 2'b00, word_q[33:32]};
        3'd1:    tx_byte = word_q[7:0];
        3'd2:    tx_byte = word_q[15:8];
        3'd3:    tx_byte = word_q[23:16];
        3'd4:    tx_byte = word_q[31:24];
        default: tx_byte = 8'h00;
      endcase
    end
  end

  assign tx_valid             = (tx_state_q == T_SEND);
  assign up_fifo_read_inc     = read_inc_q;
  assign down_fifo_write_data = {addr_q, data_q};
  assign frame_err            = frame_err_q;
  assign rx_drop              = rx_drop_q;

endmodule

// File: tb/tb_host_frame_codec.sv
// Directed bench for host_frame_codec: rx framing, timeout, full-FIFO drop, tx serialisation, reset.
module tb_host_frame_codec;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [33:0] down_fifo_write_data;
  logic        down_fifo_write_inc;
  logic        down_fifo_write_full;
  logic [33:0] up_fifo_read_data;
  logic        up_fifo_read_inc;
  logic        up_fifo_read_empty;
  logic        frame_err;
  logic        rx_drop;

  int vec_cnt = 0;
  int err_cnt = 0;

  int          wr_cnt   = 0;
  int          pop_cnt  = 0;
  int          err_evt  = 0;
  int          drop_evt = 0;
  logic [7:0]  tx_q[$];

  always #5 clk = ~clk;

  host_frame_codec #(.HDR_MAGIC(4'hA), .TIMEOUT_CYCLES(16)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rx_byte              (rx_byte),
    .rx_valid             (rx_valid),
    .tx_byte              (tx_byte),
    .tx_valid             (tx_valid),
    .tx_ready             (tx_ready),
    .down_fifo_write_data (down_fifo_write_data),
    .down_fifo_write_inc  (down_fifo_write_inc),
    .down_fifo_write_full (down_fifo_write_full),
    .up_fifo_read_data    (up_fifo_read_data),
    .up_fifo_read_inc     (up_fifo_read_inc),
    .up_fifo_read_empty   (up_fifo_read_empty),
    .frame_err            (frame_err),
    .rx_drop              (rx_drop)
  );

  always @(posedge clk) begin
    if (down_fifo_write_inc) wr_cnt <= wr_cnt + 1;
    if (up_fifo_read_inc)    pop_cnt <= pop_cnt + 1;
    if (frame_err)           err_evt <= err_evt + 1;
    if (rx_drop)             drop_evt <= drop_evt + 1;
    if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_byte = 8'h55; rx_valid = 1'b1; tx_ready = 1'b0;
    down_fifo_write_full = 1'b0; up_fifo_read_data = '0; up_fifo_read_empty = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++; if (tx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    vec_cnt++; if (tx_byte !== 8'h00) begin err_cnt++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
    vec_cnt++; if (down_fifo_write_inc !== 1'b0) begin err_cnt++; $display("FAIL reset_write_inc: got %b expected 0", down_fifo_write_inc); end
    vec_cnt++; if (down_fifo_write_data !== 34'h0) begin err_cnt++; $display("FAIL reset_write_data: got %h expected 0", down_fifo_write_data); end
    vec_cnt++; if (up_fifo_read_inc !== 1'b0) begin err_cnt++; $display("FAIL reset_read_inc: got %b expected 0", up_fifo_read_inc); end
    vec_cnt++; if (frame_err !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    vec_cnt++; if (rx_drop !== 1'b0) begin err_cnt++; $display("FAIL reset_rx_drop: got %b expected 0", rx_drop); end
    rst = 1'b0; rx_valid = 1'b0;
    idle(2);
    $display("test_reset: outputs checked in reset");
  endtask

  task automatic test_basic;
    int w0;
    w0 = wr_cnt;
    send_byte(8'hA1); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    idle(1);
    vec_cnt++; if (down_fifo_write_inc !== 1'b1) begin err_cnt++; $display("FAIL basic_inc: got %b expected 1", down_fifo_write_inc); end
    vec_cnt++; if (down_fifo_write_data !== 34'h1_12345678) begin err_cnt++; $display("FAIL basic_data: got %h expected 112345678", down_fifo_write_data); end
    idle(1);
    vec_cnt++; if (down_fifo_write_inc !== 1'b0) begin err_cnt++; $display("FAIL basic_inc_single: got %b expected 0", down_fifo_write_inc); end
    vec_cnt++; if (wr_cnt - w0 !== 1) begin err_cnt++; $display("FAIL basic_count: got %0d expected 1", wr_cnt - w0); end
    $display("test_basic: frame A1 78 56 34 12 -> %h", down_fifo_write_data);
  endtask

  task automatic test_bad_header;
    int w0, e0;
    w0 = wr_cnt; e0 = err_evt;
    send_byte(8'h51); idle(1);
    vec_cnt++; if (frame_err !== 1'b1) begin err_cnt++; $display("FAIL badhdr_magic_err: got %b expected 1", frame_err); end
    idle(1);
    vec_cnt++; if (frame_err !== 1'b0) begin err_cnt++; $display("FAIL badhdr_pulse_width: got %b expected 0", frame_err); end
    send_byte(8'hA4); idle(1);
    vec_cnt++; if (frame_err !== 1'b1) begin err_cnt++; $display("FAIL badhdr_reserved_err: got %b expected 1", frame_err); end
    idle(1);
    send_byte(8'hA0); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(1);
    vec_cnt++; if (down_fifo_write_inc !== 1'b1) begin err_cnt++; $display("FAIL badhdr_next_inc: got %b expected 1", down_fifo_write_inc); end
    vec_cnt++; if (down_fifo_write_data !== 34'h0_00000001) begin err_cnt++; $display("FAIL badhdr_next_data: got %h expected 000000001", down_fifo_write_data); end
    idle(1);
    vec_cnt++; if (err_evt - e0 !== 2) begin err_cnt++; $display("FAIL badhdr_err_count: got %0d expected 2", err_evt - e0); end
    vec_cnt++; if (wr_cnt - w0 !== 1) begin err_cnt++; $display("FAIL badhdr_write_count: got %0d expected 1", wr_cnt - w0); end
    $display("test_bad_header: 51 and A4 rejected, A0 frame accepted");
  endtask

  task automatic test_timeout;
    int w0, e0, hit;
    w0 = wr_cnt; e0 = err_evt; hit = 0;
    send_byte(8'hA2); send_byte(8'h11); send_byte(8'h22);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (frame_err && hit == 0) hit = k;
    end
    vec_cnt++; if (hit !== 17) begin err_cnt++; $display("FAIL timeout_cycle: got %0d expected 17", hit); end
    vec_cnt++; if (err_evt - e0 !== 1) begin err_cnt++; $display("FAIL timeout_err_count: got %0d expected 1", err_evt - e0); end
    vec_cnt++; if (wr_cnt - w0 !== 0) begin err_cnt++; $display("FAIL timeout_no_write: got %0d expected 0", wr_cnt - w0); end
    send_byte(8'hA2); send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    idle(1);
    vec_cnt++; if (down_fifo_write_data !== 34'h2_DEADBEEF || down_fifo_write_inc !== 1'b1) begin err_cnt++; $display("FAIL timeout_next_frame: got %h inc %b expected 2deadbeef inc 1", down_fifo_write_data, down_fifo_write_inc); end
    idle(1);
    send_byte(8'hA3); send_byte(8'h44); idle(12);
    send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    idle(1);
    vec_cnt++; if (down_fifo_write_data !== 34'h3_11223344 || down_fifo_write_inc !== 1'b1) begin err_cnt++; $display("FAIL timeout_gap_ok: got %h inc %b expected 311223344 inc 1", down_fifo_write_data, down_fifo_write_inc); end
    idle(1);
    vec_cnt++; if (err_evt - e0 !== 1) begin err_cnt++; $display("FAIL timeout_gap_no_err: got %0d expected 1", err_evt - e0); end
    $display("test_timeout: timeout after %0d cycles, gap of 12 tolerated", hit);
  endtask

  task automatic test_full;
    int w0, d0;
    w0 = wr_cnt; d0 = drop_evt;
    down_fifo_write_full = 1'b1;
    send_byte(8'hA1); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h99);
    vec_cnt++; if (down_fifo_write_inc !== 1'b0) begin err_cnt++; $display("FAIL full_no_inc: got %b expected 0", down_fifo_write_inc); end
    idle(1);
    vec_cnt++; if (rx_drop !== 1'b1) begin err_cnt++; $display("FAIL full_rx_drop: got %b expected 1", rx_drop); end
    idle(3);
    vec_cnt++; if (wr_cnt - w0 !== 0 || drop_evt - d0 !== 1) begin err_cnt++; $display("FAIL full_hold: got writes %0d drops %0d expected 0 1", wr_cnt - w0, drop_evt - d0); end
    @(negedge clk);
    down_fifo_write_full = 1'b0;
    rx_byte = 8'hA1; rx_valid = 1'b1;
    #1;
    vec_cnt++; if (down_fifo_write_inc !== 1'b1) begin err_cnt++; $display("FAIL full_release_inc: got %b expected 1", down_fifo_write_inc); end
    vec_cnt++; if (down_fifo_write_data !== 34'h1_12345678) begin err_cnt++; $display("FAIL full_release_data: got %h expected 112345678", down_fifo_write_data); end
    idle(1);
    vec_cnt++; if (down_fifo_write_inc !== 1'b0) begin err_cnt++; $display("FAIL full_single_inc: got %b expected 0", down_fifo_write_inc); end
    vec_cnt++; if (rx_drop !== 1'b1) begin err_cnt++; $display("FAIL full_hdr_dropped: got %b expected 1", rx_drop); end
    idle(1);
    vec_cnt++; if (rx_drop !== 1'b0) begin err_cnt++; $display("FAIL full_drop_width: got %b expected 0", rx_drop); end
    vec_cnt++; if (wr_cnt - w0 !== 1 || drop_evt - d0 !== 2) begin err_cnt++; $display("FAIL full_counts: got writes %0d drops %0d expected 1 2", wr_cnt - w0, drop_evt - d0); end
    $display("test_full: held word pushed once, 2 bytes dropped");
  endtask

  task automatic test_tx;
    int p0;
    logic got, hold, ready;
    logic [7:0] held_byte;
    logic [15:0] pat;
    logic [7:0] exp_b [5];
    exp_b = '{8'hA3, 8'h01, 8'h00, 8'h00, 8'h00};
    pat = 16'b0110_1001_1001_0110;
    tx_q.delete(); p0 = pop_cnt; got = 1'b0; hold = 1'b0; held_byte = 8'h00;
    @(negedge clk);
    tx_ready = 1'b0; up_fifo_read_data = 34'h3_00000001; up_fifo_read_empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (up_fifo_read_inc) begin up_fifo_read_empty = 1'b1; got = 1'b1; break; end
    end
    vec_cnt++; if (got !== 1'b1) begin err_cnt++; $display("FAIL tx_read_inc: got %b expected 1", got); end
    for (int c = 0; c < 40; c++) begin
      if (hold) begin
        vec_cnt++; if (tx_valid !== 1'b1 || tx_byte !== held_byte) begin err_cnt++; $display("FAIL tx_stable: got valid %b byte %h expected 1 %h", tx_valid, tx_byte, held_byte); end
      end
      if (tx_q.size() == 5 && !tx_valid) break;
      ready = pat[c % 16];
      hold = tx_valid && !ready;
      held_byte = tx_byte;
      tx_ready = ready;
      @(negedge clk);
    end
    tx_ready = 1'b0;
    vec_cnt++; if (tx_q.size() !== 5) begin err_cnt++; $display("FAIL tx_byte_count: got %0d expected 5", tx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < tx_q.size()) begin
        vec_cnt++; if (tx_q[i] !== exp_b[i]) begin err_cnt++; $display("FAIL tx_byte%0d: got %h expected %h", i, tx_q[i], exp_b[i]); end
      end
    end
    vec_cnt++; if (pop_cnt - p0 !== 1) begin err_cnt++; $display("FAIL tx_pop_count: got %0d expected 1", pop_cnt - p0); end
    vec_cnt++; if (tx_valid !== 1'b0) begin err_cnt++; $display("FAIL tx_end_valid: got %b expected 0", tx_valid); end
    $display("test_tx: word 300000001 sent as %0d bytes with toggling ready", tx_q.size());
  endtask

  task automatic test_back_to_back;
    int p0, n;
    logic [7:0] exp_b [10];
    exp_b = '{8'hA1, 8'h80, 8'h00, 8'hFF, 8'h00, 8'hA0, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    tx_q.delete(); p0 = pop_cnt; n = 0;
    fork
      begin
        send_byte(8'hA2); send_byte(8'hEF); send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h89);
        idle(1);
        vec_cnt++; if (down_fifo_write_data !== 34'h2_89ABCDEF || down_fifo_write_inc !== 1'b1) begin err_cnt++; $display("FAIL b2b_rx_word: got %h inc %b expected 289abcdef inc 1", down_fifo_write_data, down_fifo_write_inc); end
      end
      begin
        @(negedge clk);
        tx_ready = 1'b1; up_fifo_read_data = 34'h1_00FF0080; up_fifo_read_empty = 1'b0;
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (up_fifo_read_inc) begin
            n++;
            if (n == 1) up_fifo_read_data = 34'h0_CAFEF00D;
            else        up_fifo_read_empty = 1'b1;
          end
          if (tx_q.size() == 10) break;
        end
        tx_ready = 1'b0;
      end
    join
    vec_cnt++; if (tx_q.size() !== 10) begin err_cnt++; $display("FAIL b2b_byte_count: got %0d expected 10", tx_q.size()); end
    for (int i = 0; i < 10; i++) begin
      if (i < tx_q.size()) begin
        vec_cnt++; if (tx_q[i] !== exp_b[i]) begin err_cnt++; $display("FAIL b2b_byte%0d: got %h expected %h", i, tx_q[i], exp_b[i]); end
      end
    end
    vec_cnt++; if (pop_cnt - p0 !== 2) begin err_cnt++; $display("FAIL b2b_pop_count: got %0d expected 2", pop_cnt - p0); end
    idle(2);
    $display("test_back_to_back: two tx words and one rx word concurrently");
  endtask

  task automatic test_reset_mid;
    int p0, bad;
    logic got;
    tx_q.delete(); got = 1'b0;
    @(negedge clk);
    tx_ready = 1'b1; up_fifo_read_data = 34'h3_44332211; up_fifo_read_empty = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (up_fifo_read_inc) up_fifo_read_empty = 1'b1;
      if (tx_q.size() == 2) break;
    end
    vec_cnt++; if (tx_q.size() !== 2 || tx_valid !== 1'b1 || tx_byte !== 8'h22) begin err_cnt++; $display("FAIL rstmid_pre: got count %0d valid %b byte %h expected 2 1 22", tx_q.size(), tx_valid, tx_byte); end
    rst = 1'b1; tx_ready = 1'b0;
    @(negedge clk);
    vec_cnt++; if (tx_valid !== 1'b0 || tx_byte !== 8'h00) begin err_cnt++; $display("FAIL rstmid_abandon: got valid %b byte %h expected 0 00", tx_valid, tx_byte); end
    rst = 1'b0;
    p0 = pop_cnt; bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (up_fifo_read_inc || tx_valid) bad++;
    end
    vec_cnt++; if (bad !== 0 || pop_cnt !== p0) begin err_cnt++; $display("FAIL rstmid_quiet: got active cycles %0d pops %0d expected 0 0", bad, pop_cnt - p0); end
    tx_q.delete();
    up_fifo_read_data = 34'h1_000000AA; up_fifo_read_empty = 1'b0; tx_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (up_fifo_read_inc) begin up_fifo_read_empty = 1'b1; got = 1'b1; end
      if (tx_q.size() == 5 && !tx_valid) break;
    end
    tx_ready = 1'b0;
    vec_cnt++; if (got !== 1'b1 || pop_cnt - p0 !== 1) begin err_cnt++; $display("FAIL rstmid_new_pop: got seen %b pops %0d expected 1 1", got, pop_cnt - p0); end
    vec_cnt++; if (tx_q.size() !== 5) begin err_cnt++; $display("FAIL rstmid_new_count: got %0d expected 5", tx_q.size()); end
    else begin
      vec_cnt++; if (tx_q[0] !== 8'hA1 || tx_q[1] !== 8'hAA) begin err_cnt++; $display("FAIL rstmid_new_bytes: got %h %h expected a1 aa", tx_q[0], tx_q[1]); end
    end
    $display("test_reset_mid: tx frame abandoned on reset, next word sent");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_header();
    test_timeout();
    test_full();
    test_tx();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
